// File: rtl/timer_irq_servicer_if.sv
// -----------------------------------------------------------------------------
// timer_irq_servicer_if
// Bus between the IRQ servicer and the hardware timer it drives.
//   tmr_write    : servicer -> timer, restart strobe that also loads the compare
//   tmr_read     : servicer -> timer, status read strobe (timer clears its IRQ
//                  on the falling edge of this strobe)
//   tmr_irq_time : servicer -> timer, 32-bit compare value
//   tmr_data_in  : timer -> servicer, status word (bit 0 = IRQ pending)
//   tmr_irq      : timer -> servicer, interrupt line
// master = servicer side, slave = timer side.
// -----------------------------------------------------------------------------
interface timer_irq_servicer_if;
  logic        tmr_write;
  logic        tmr_read;
  logic [31:0] tmr_irq_time;
  logic [31:0] tmr_data_in;
  logic        tmr_irq;

  modport master (
    output tmr_write,
    output tmr_read,
    output tmr_irq_time,
    input  tmr_data_in,
    input  tmr_irq
  );

  modport slave (
    input  tmr_write,
    input  tmr_read,
    input  tmr_irq_time,
    output tmr_data_in,
    output tmr_irq
  );
endinterface

// File: rtl/timer_irq_servicer.sv
// -----------------------------------------------------------------------------
// timer_irq_servicer
// Arms a hardware timer, waits for its interrupt, reads the status to clear it,
// confirms the clear, and repeats until count_limit interrupts are serviced
// (count_limit = 0 runs until stop). A clear that does not happen within
// CLR_TIMEOUT cycles raises a sticky err and abandons the sequence.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start, stop       : begin (IDLE only) / abort (any active state) requests
//   period            : compare value, latched on accepted start
//   count_limit       : interrupts to service, latched on accepted start
//   bus (master)      : timer bus, see timer_irq_servicer_if
//   busy              : high in every state except IDLE
//   tick              : one-cycle pulse per serviced interrupt
//   done              : one-cycle pulse when count_limit is reached
//   err               : sticky clear-timeout flag
//   event_count       : interrupts serviced since the last accepted start
// All outputs are registered.
// -----------------------------------------------------------------------------
module timer_irq_servicer #(
  parameter int unsigned CLR_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [31:0]                 period,
  input  logic [15:0]                 count_limit,
  timer_irq_servicer_if.master        bus,
  output logic                        busy,
  output logic                        tick,
  output logic                        done,
  output logic                        err,
  output logic [15:0]                 event_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    READ    = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Release counter runs 0 .. CLR_TIMEOUT-1, one count per RELEASE cycle.
  localparam int unsigned CW = (CLR_TIMEOUT < 2) ? 1 : $clog2(CLR_TIMEOUT);
  localparam logic [CW-1:0] REL_LAST = CW'(CLR_TIMEOUT - 1);

  state_t        state_r;
  logic [15:0]   limit_r;
  logic [CW-1:0] rel_cnt_r;
  logic          irq_clear_s;
  logic [15:0]   next_count_s;

  // Only bit 0 of the status word carries meaning.
  logic unused_data_s;
  assign unused_data_s = &{1'b0, bus.tmr_data_in[31:1]};

  assign irq_clear_s  = ~bus.tmr_irq & ~bus.tmr_data_in[0];
  assign next_count_s = event_count + 16'd1;

  // Service sequencer: state, latched parameters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r          <= IDLE;
      limit_r          <= 16'd0;
      rel_cnt_r        <= {CW{1'b0}};
      bus.tmr_write    <= 1'b0;
      bus.tmr_read     <= 1'b0;
      bus.tmr_irq_time <= 32'd0;
      busy             <= 1'b0;
      tick             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      event_count      <= 16'd0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      bus.tmr_write <= 1'b0;
      bus.tmr_read  <= 1'b0;
      tick          <= 1'b0;
      done          <= 1'b0;
      case (state_r)
        IDLE: begin
          // start together with stop is treated as no request.
          if (start && !stop) begin
            state_r          <= ARM;
            bus.tmr_irq_time <= period;
            limit_r          <= count_limit;
            event_count      <= 16'd0;
            err              <= 1'b0;
            busy             <= 1'b1;
            bus.tmr_write    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ARM: begin
          if (stop) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (stop) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (bus.tmr_irq) begin
            state_r      <= READ;
            bus.tmr_read <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        READ: begin
          if (stop) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r   <= RELEASE;
            rel_cnt_r <= {CW{1'b0}};
          end
        end
        RELEASE: begin
          if (stop) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (irq_clear_s) begin
            event_count <= next_count_s;
            tick        <= 1'b1;
            if ((limit_r != 16'd0) && (next_count_s == limit_r)) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r       <= ARM;
              bus.tmr_write <= 1'b1;
            end
          end else if (rel_cnt_r == REL_LAST) begin
            // Timer never dropped its IRQ: give up on this sequence.
            state_r <= IDLE;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_r   <= RELEASE;
            rel_cnt_r <= rel_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          busy          <= 1'b0;
          bus.tmr_write <= 1'b0;
          bus.tmr_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_servicer.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_servicer
// Drives timer_irq_servicer against a behavioural one-shot timer. Expected
// (event_count, compare value) pairs are queued when a run is started and
// popped on every tick pulse.
// -----------------------------------------------------------------------------
module tb_timer_irq_servicer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] period;
  logic [15:0] count_limit;
  logic        busy;
  logic        tick;
  logic        done;
  logic        err;
  logic [15:0] event_count;

  int errors = 0;
  int checks = 0;
  int write_cnt = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [15:0] ev;
    logic [31:0] t;
  } exp_t;
  exp_t sb[$];

  timer_irq_servicer_if bus();

  timer_irq_servicer #(.CLR_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .period      (period),
    .count_limit (count_limit),
    .bus         (bus),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .err         (err),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  // Behavioural timer: one-shot compare, IRQ cleared on falling edge of read
  // unless 'stuck' models a timer that never clears.
  logic        stuck = 1'b0;
  logic        irq_r;
  logic        running_r;
  logic        prev_read_r;
  logic [31:0] cnt_r;
  logic [31:0] cmp_r;
  logic [30:0] junk_r;

  assign bus.tmr_irq     = irq_r;
  assign bus.tmr_data_in = {junk_r, irq_r};

  always @(posedge clk) begin
    prev_read_r <= bus.tmr_read;
    junk_r      <= 31'($urandom());
    if (rst !== 1'b1) begin
      irq_r     <= 1'b0;
      running_r <= 1'b0;
      cnt_r     <= 32'd0;
      cmp_r     <= 32'd0;
    end else if (bus.tmr_write === 1'b1) begin
      cmp_r     <= bus.tmr_irq_time;
      cnt_r     <= 32'd0;
      running_r <= 1'b1;
      irq_r     <= 1'b0;
    end else begin
      if (running_r) begin
        cnt_r <= cnt_r + 32'd1;
        if (cnt_r + 32'd1 >= cmp_r) begin
          irq_r     <= 1'b1;
          running_r <= 1'b0;
        end
      end
      if (prev_read_r && (bus.tmr_read === 1'b0) && !stuck) irq_r <= 1'b0;
    end
  end

  // Scoreboard: each tick must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (tick === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick event_count=%0d", event_count);
      end else begin
        e = sb.pop_front();
        if (event_count !== e.ev || bus.tmr_irq_time !== e.t) begin
          errors++;
          $display("FAIL tick_value got ev=%0d time=%0d want ev=%0d time=%0d",
                   event_count, bus.tmr_irq_time, e.ev, e.t);
        end
      end
    end
    if (bus.tmr_write === 1'b1) write_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // Bus invariants: strobes exclusive, compare value stable while busy.
  logic        prev_busy = 1'b0;
  logic [31:0] prev_time = 32'd0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if (bus.tmr_write === 1'b1 && bus.tmr_read === 1'b1) begin
        errors++;
        $display("FAIL strobe_overlap write=1 read=1 required not both");
      end
      if (busy === 1'b1 && prev_busy === 1'b1) begin
        checks++;
        if (bus.tmr_irq_time !== prev_time) begin
          errors++;
          $display("FAIL irq_time_stable got %0d required %0d", bus.tmr_irq_time, prev_time);
        end
      end
    end
    prev_busy = busy;
    prev_time = bus.tmr_irq_time;
  end

  task automatic pulse_start(input logic [31:0] p, input logic [15:0] l);
    period      = p;
    count_limit = l;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; stop = 1'b0; period = 32'd0; count_limit = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, tick, done, err, bus.tmr_write, bus.tmr_read} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 000000",
               {busy, tick, done, err, bus.tmr_write, bus.tmr_read});
    end
    checks++;
    if (event_count !== 16'd0 || bus.tmr_irq_time !== 32'd0) begin
      errors++;
      $display("FAIL reset_values got ev=%0d time=%0d required 0 0", event_count, bus.tmr_irq_time);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.tmr_write !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start got busy=%b write=%b required 0 0", busy, bus.tmr_write);
    end
  endtask

  task automatic test_count3;
    int n = 0;
    write_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 3; i++) sb.push_back({16'(i), 32'd5});
    pulse_start(32'd5, 16'd3);
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL count3_done_timeout got no done required done"); end
    checks++;
    if (event_count !== 16'd3) begin
      errors++; $display("FAIL count3_event_count got %0d required 3", event_count);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL count3_after_done got busy=%b done=%b err=%b required 0 0 0", busy, done, err);
    end
    checks++;
    if (write_cnt != 3 || done_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL count3_pulses got writes=%0d dones=%0d left=%0d required 3 1 0",
               write_cnt, done_cnt, sb.size());
    end
  endtask

  task automatic test_free_run;
    int n = 0;
    int ticks = 0;
    done_cnt = 0;
    for (int i = 1; i <= 4; i++) sb.push_back({16'(i), 32'd2});
    pulse_start(32'd2, 16'd0);
    while (ticks < 4 && n < 400) begin
      @(negedge clk); n++;
      if (tick === 1'b1) ticks++;
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL free_run_tick_timeout got %0d ticks required 4", ticks); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || event_count !== 16'd4) begin
      errors++; $display("FAIL free_run_stop got busy=%b ev=%0d required 0 4", busy, event_count);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != 0 || sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL free_run_after_stop got dones=%0d left=%0d busy=%b required 0 0 0",
               done_cnt, sb.size(), busy);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    sb.push_back({16'd1, 32'd3});
    pulse_start(32'd3, 16'd2);
    while (tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    stuck = 1'b1;
    n = 0;
    while (bus.tmr_read !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL timeout_no_read got no read required read"); end
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk);
      if (err !== 1'b1) n++;
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL timeout_release_cycles got %0d required 8", n); end
    checks++;
    if (busy !== 1'b0 || event_count !== 16'd1 || tick !== 1'b0) begin
      errors++; $display("FAIL timeout_state got busy=%b ev=%0d tick=%b required 0 1 0", busy, event_count, tick);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || sb.size() != 0) begin
      errors++; $display("FAIL timeout_err_sticky got err=%b left=%0d required 1 0", err, sb.size());
    end
  endtask

  task automatic test_ignore;
    int n = 0;
    stuck = 1'b0;
    done_cnt = 0;
    period = 32'd9; count_limit = 16'd7; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || event_count !== 16'd1 ||
        bus.tmr_write !== 1'b0 || bus.tmr_irq_time !== 32'd3) begin
      errors++;
      $display("FAIL start_stop_idle got busy=%b err=%b ev=%0d write=%b time=%0d required 0 1 1 0 3",
               busy, err, event_count, bus.tmr_write, bus.tmr_irq_time);
    end
    for (int i = 1; i <= 2; i++) sb.push_back({16'(i), 32'd6});
    pulse_start(32'd6, 16'd2);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || event_count !== 16'd0 || bus.tmr_irq_time !== 32'd6) begin
      errors++;
      $display("FAIL start_clears got busy=%b err=%b ev=%0d time=%0d required 1 0 0 6",
               busy, err, event_count, bus.tmr_irq_time);
    end
    pulse_start(32'd9, 16'd1);
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400 || event_count !== 16'd2 || bus.tmr_irq_time !== 32'd6) begin
      errors++;
      $display("FAIL busy_start_ignored got wait=%0d ev=%0d time=%0d required <400 2 6",
               n, event_count, bus.tmr_irq_time);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start_end got busy=%b left=%0d dones=%0d required 0 0 1", busy, sb.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_read;
    int n = 0;
    for (int i = 1; i <= 5; i++) sb.push_back({16'(i), 32'd4});
    pulse_start(32'd4, 16'd5);
    while (bus.tmr_read !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL mid_read_no_read got no read required read"); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, tick, done, err, bus.tmr_write, bus.tmr_read} !== 6'b0 ||
        event_count !== 16'd0 || bus.tmr_irq_time !== 32'd0) begin
      errors++;
      $display("FAIL mid_read_reset got flags=%b ev=%0d time=%0d required 000000 0 0",
               {busy, tick, done, err, bus.tmr_write, bus.tmr_read}, event_count, bus.tmr_irq_time);
    end
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    sb.push_back({16'd1, 32'd3});
    pulse_start(32'd3, 16'd1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200 || event_count !== 16'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run got wait=%0d ev=%0d err=%b required <200 1 0", n, event_count, err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL post_reset_idle got busy=%b left=%0d required 0 0", busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_count3();
    test_free_run();
    test_timeout();
    test_ignore();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
